// File: rtl/snn_pkg.sv
// Shared SNN decode definitions: window length, time-field width and decoder states.
`ifndef TIME_PERIOD_DEF
`define TIME_PERIOD_DEF 16
`endif

package snn_pkg;

    localparam int unsigned SNN_TIME_PERIOD = `TIME_PERIOD_DEF;
    localparam int unsigned SNN_TIME_W      = $clog2(SNN_TIME_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_HOLD   = 2'd2
    } dec_state_e;

endpackage

// File: rtl/spike_time_counter.sv
// Window time-step counter: clears to zero, counts up while enabled, flags the last step.
module spike_time_counter #(
    parameter int unsigned W        = 4,
    parameter int unsigned TERMINAL = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         enable_i,
    output logic [W-1:0] value_o,
    output logic         terminal_c
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (enable_i) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o    = value_q;
    assign terminal_c = (value_q == W'(TERMINAL));

endmodule

// File: rtl/spike_decoder.sv
// Temporal-code spike decoder: measures the leading run of high samples over one
// window and flags any violation of the "high then low" coding rule.
module spike_decoder
    import snn_pkg::*;
#(
    parameter int unsigned TIME_PERIOD = SNN_TIME_PERIOD
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           spike_in,
    input  logic                           out_ready,
    output logic                           busy,
    output logic [$clog2(TIME_PERIOD)-1:0] time_val,
    output logic                           out_valid,
    output logic [$clog2(TIME_PERIOD)-1:0] out_spike_time,
    output logic                           out_should_spike,
    output logic                           out_error
);

    localparam int unsigned W = $clog2(TIME_PERIOD);
    localparam logic [W-1:0] RUN_MAX = W'(TIME_PERIOD - 1);

    dec_state_e   state_q, state_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic         in_window_c, tc_c, first_c;
    logic [W-1:0] run_q, run_d, run_base_c;
    logic         low_q, low_d, low_base_c;
    logic         err_q, err_d, err_base_c;
    logic         should_q, should_d;
    logic [W-1:0] res_time_q;
    logic         res_should_q, res_err_q;

    assign in_window_c = (state_q == ST_WINDOW);

    spike_time_counter #(
        .W        (W),
        .TERMINAL (TIME_PERIOD - 1)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (!in_window_c || tc_c),
        .enable_i   (in_window_c),
        .value_o    (time_val),
        .terminal_c (tc_c)
    );

    // Next state plus the running decode; step 0 restarts the accumulators.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_WINDOW;
            ST_WINDOW: if (tc_c) state_d = ST_HOLD;
            ST_HOLD:   if (out_ready) state_d = start ? ST_WINDOW : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_WINDOW);
        valid_d = (state_d == ST_HOLD);

        first_c    = (time_val == '0);
        run_base_c = first_c ? '0   : run_q;
        low_base_c = first_c ? 1'b0 : low_q;
        err_base_c = first_c ? 1'b0 : err_q;
        should_d   = first_c ? spike_in : should_q;
        low_d      = low_base_c | !spike_in;
        err_d      = err_base_c | (spike_in & low_base_c) | (spike_in & tc_c);
        run_d      = run_base_c;
        if (spike_in && !low_base_c && (run_base_c != RUN_MAX)) begin
            run_d = run_base_c + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            run_q        <= '0;
            low_q        <= 1'b0;
            err_q        <= 1'b0;
            should_q     <= 1'b0;
            res_time_q   <= '0;
            res_should_q <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            if (in_window_c) begin
                run_q    <= run_d;
                low_q    <= low_d;
                err_q    <= err_d;
                should_q <= should_d;
            end
            // Results only move when a window completes.
            if (in_window_c && tc_c) begin
                res_time_q   <= run_d;
                res_should_q <= should_d;
                res_err_q    <= err_d;
            end
        end
    end

    assign busy             = busy_q;
    assign out_valid        = valid_q;
    assign out_spike_time   = res_time_q;
    assign out_should_spike = res_should_q;
    assign out_error        = res_err_q;

endmodule
